// File: rtl/keypad_scanner.sv
// Column-strobed 4x4 active-low keypad scanner with whole-scan debounce.
// Emits one key_valid pulse per debounced press; key_code holds the last accepted key.
module keypad_scanner #(
  parameter int SCAN_CYCLES    = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_err
);

  localparam int DW = $clog2(SCAN_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2,
    S_RELEASE  = 2'd3
  } state_e;

  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    acc_cnt_q, acc_cnt_d;
  logic [3:0]    acc_code_q, acc_code_d;

  logic          sample;
  logic          scan_end;
  logic [2:0]    col_hits;
  logic [2:0]    hit_sum;
  logic [1:0]    scan_cnt;
  logic [3:0]    scan_code;
  logic          res_none, res_one, res_multi;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    cand_q;
  logic [3:0]    key_code_q;
  logic          key_valid_q, key_held_q, multi_err_q;

  assign col = ~(4'b0001 << col_idx_q);

  always_comb begin
    sample    = (dwell_q == DWELL_LAST);
    scan_end  = sample && (col_idx_q == 2'd3);
    col_hits  = '0;
    scan_code = acc_code_q;
    // Later rows overwrite earlier ones, so the code is the last pressed key seen.
    for (int r = 0; r < 4; r++) begin
      if (!row[r]) begin
        col_hits  = col_hits + 3'd1;
        scan_code = {col_idx_q, r[1:0]};
      end
    end
    hit_sum   = {1'b0, acc_cnt_q} + col_hits;
    scan_cnt  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    res_none  = scan_end && (scan_cnt == 2'd0);
    res_one   = scan_end && (scan_cnt == 2'd1);
    res_multi = scan_end && (scan_cnt == 2'd2);

    dwell_d    = sample ? '0 : dwell_q + DW'(1);
    col_idx_d  = sample ? col_idx_q + 2'd1 : col_idx_q;
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    if (scan_end) begin
      acc_cnt_d  = '0;
      acc_code_d = '0;
    end else if (sample) begin
      acc_cnt_d  = scan_cnt;
      acc_code_d = scan_code;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dwell_q    <= '0;
      col_idx_q  <= '0;
      acc_cnt_q  <= '0;
      acc_code_q <= '0;
    end else begin
      dwell_q    <= dwell_d;
      col_idx_q  <= col_idx_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      multi_err_q <= 1'b0;
      if (scan_end) begin
        case (state_q)
          S_IDLE: begin
            if (res_one) begin
              cand_q <= scan_code;
              if (DEBOUNCE_SCANS == 1) begin
                state_q     <= S_PRESSED;
                cnt_q       <= CW'(DEBOUNCE_SCANS);
                key_code_q  <= scan_code;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
              end else begin
                state_q <= S_DEBOUNCE;
                cnt_q   <= CW'(1);
              end
            end else if (res_multi) begin
              multi_err_q <= 1'b1;
            end
          end
          S_DEBOUNCE: begin
            if (res_one && (scan_code == cand_q)) begin
              if (int'(cnt_q) + 1 >= DEBOUNCE_SCANS) begin
                state_q     <= S_PRESSED;
                cnt_q       <= CW'(DEBOUNCE_SCANS);
                key_code_q  <= cand_q;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end else if (res_one) begin
              cand_q <= scan_code;
              cnt_q  <= CW'(1);
            end else begin
              state_q     <= S_IDLE;
              cnt_q       <= '0;
              multi_err_q <= res_multi;
            end
          end
          S_PRESSED: begin
            // No auto-repeat: any key activity simply keeps the press alive.
            if (res_none) begin
              if (DEBOUNCE_SCANS == 1) begin
                state_q    <= S_IDLE;
                cnt_q      <= '0;
                key_held_q <= 1'b0;
              end else begin
                state_q <= S_RELEASE;
                cnt_q   <= CW'(1);
              end
            end
          end
          default: begin
            if (res_none) begin
              if (int'(cnt_q) + 1 >= DEBOUNCE_SCANS) begin
                state_q    <= S_IDLE;
                cnt_q      <= '0;
                key_held_q <= 1'b0;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end else begin
              state_q <= S_PRESSED;
              cnt_q   <= CW'(DEBOUNCE_SCANS);
            end
          end
        endcase
      end
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_err = multi_err_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Front-end stage for the digital combination lock. Scans a 4x4 active-low matrix keypad, debounces it, and delivers one 4-bit key code per debounced press on `key_code`, qualified by a single-cycle `key_valid` pulse. `key_code` drives the lock FSM's 4-bit digit input. `key_valid` is the strobe that advances the lock sequence.

## Interface

Parameters:

- `SCAN_CYCLES`, default 4: clock cycles each column stays driven (dwell). Legal values are 2 or more.
- `DEBOUNCE_SCANS`, default 3: number of consecutive identical full-scan results needed to accept a press or a release. Legal values are 1 or more.

Ports:

- `clk`  input  1: single system clock; all logic is on the rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `row`  input  4: keypad row lines, active-low (pull-ups on the board). Treated as synchronous to `clk`.
- `col`  output  4: keypad column strobes. Active-low, exactly one bit low at a time.
- `key_code`  output  4: last accepted key, encoded as `4*col_idx + row_idx`.
- `key_valid`  output  1: one-cycle pulse when a new key is accepted.
- `key_held`  output  1: high while the accepted key is pressed or its release is still being debounced.
- `multi_err`  output  1: one-cycle pulse when a scan sees two or more keys while no key is accepted.

## Operation

Scanner:
- `col_idx` steps 0, 1, 2, 3, 0, …, advancing every `SCAN_CYCLES` cycles.
- `col = ~(4'b0001 << col_idx)`.
- Rows are sampled on the last dwell cycle of each column. Key (c, r) counts as pressed when `row[r] == 0` during column c.
- Per scan, the block accumulates the pressed-key count (saturating at 2) and the code of the last pressed key.
- On the column-3 sample, the scan result is one of:
  - NONE: no key pressed.
  - ONE(code): exactly one key pressed.
  - MULTI: two or more keys pressed.
- The scan accumulator then clears.

FSM (evaluated only on scan-end cycles; all other cycles hold state):
- **IDLE**
  - ONE(c) → DEBOUNCE with `cand = c`, `cnt = 1`. If `DEBOUNCE_SCANS == 1`, go straight to PRESSED and accept instead.
  - MULTI → pulse `multi_err`, stay in IDLE.
  - NONE → stay in IDLE.
- **DEBOUNCE**
  - ONE(`cand`) → `cnt + 1`. When `cnt` reaches `DEBOUNCE_SCANS`, go to PRESSED, load `key_code = cand`, pulse `key_valid`.
  - ONE(other) → `cand = other`, `cnt = 1`.
  - NONE → IDLE.
  - MULTI → IDLE and pulse `multi_err`.
- **PRESSED**
  - NONE → RELEASE with `cnt = 1`. If `DEBOUNCE_SCANS == 1`, go directly to IDLE.
  - ONE or MULTI → stay in PRESSED. There is no auto-repeat and no `multi_err`.
- **RELEASE**
  - NONE → `cnt + 1`. When `cnt` reaches `DEBOUNCE_SCANS`, go to IDLE.
  - ONE or MULTI → return to PRESSED with no new `key_valid`.

Outputs:
- `key_held` = 1 in PRESSED and RELEASE.
- `key_code` holds its value until the next acceptance.
- `key_valid` and `multi_err` are registered. They are never asserted in the same cycle.

Widths and arithmetic:
- Dwell counter is `$clog2(SCAN_CYCLES)` bits and wraps at `SCAN_CYCLES - 1`.
- `col_idx` is 2 bits and wraps naturally from 3 to 0.
- `cnt` is `$clog2(DEBOUNCE_SCANS + 1)` bits, saturating, and never overflows.

## Timing

- Reset is asynchronous. On `reset_n` low, immediately:
  - `col = 4'b1110`
  - dwell counter = 0, `col_idx` = 0, accumulator cleared
  - state = IDLE, `cnt = 0`, `cand = 0`
  - `key_code = 0`, `key_valid = 0`, `key_held = 0`, `multi_err = 0`
- Reset release: scanning starts on the first rising edge with `reset_n` high. Column 0 dwells a full `SCAN_CYCLES` cycles.
- Scan period: `4*SCAN_CYCLES` cycles, 16 by default.
- Scan-end edge: the edge at the end of column 3's last dwell cycle.
- Press latency: for a key stable across whole scans, `key_valid` rises one cycle after the `DEBOUNCE_SCANS`-th consecutive matching scan-end. With defaults, a key held from reset release gives `key_valid` high in cycle 49, counted from 1.
- Release latency: `key_held` falls one cycle after the `DEBOUNCE_SCANS`-th consecutive NONE scan-end.
- A press beginning mid-scan may be seen in that partial scan. Acceptance timing is set solely by scan results.
- `reset_n` asserted mid-debounce or mid-press aborts with no pulse. After reset, a still-held key must re-debounce fully and then produces a fresh `key_valid`.

## Test plan

- **Reset and scan.** Hold `reset_n = 0`, check all reset values. Release reset, check `col` sequence 1110 → 1101 → 1011 → 0111, 4 cycles each, repeating.
- **Clean press.** Drive `row[1] = 0` whenever `col[2] = 0` for 5 scans, then release. Check exactly one `key_valid` pulse with `key_code = 9` on the third scan-end+1. Check `key_held` high until 3 NONE scans after release.
- **Bounce.** Press key 5 for 2 scans, then release. Check no `key_valid`, `key_held` stays 0, `key_code` unchanged.
- **Two keys.** Press keys 0 and 6 together for 4 scans from IDLE. Check one `multi_err` pulse per scan-end, no `key_valid`. Then drop key 6 and check key 0 is accepted after 3 scans.
- **Release glitch.** While PRESSED with key 3, give 1 NONE scan, then key 3 again for 2 scans, then release. Check no second `key_valid` and `key_held` stays continuously high until the final release debounce.
- **Reset mid-debounce.** Press key 12. Assert `reset_n` after 2 scans and hold the key. Check outputs reset immediately, then `key_valid` with `key_code = 12` exactly 3 full scans after reset release.
